// File: rtl/maxnet_frame_loader.sv
// Serial-to-parallel frame loader and sequencer for the Maxnet datapath.
// Collects six float words, strobes ld, runs prime/iterate phases and returns the winner or a timeout.
module maxnet_frame_loader #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 64,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] x4,
    output logic [WIDTH-1:0] w1,
    output logic [WIDTH-1:0] w2,
    output logic             ld,
    output logic             sel,
    input  logic             dp_done,
    input  logic [WIDTH-1:0] dp_max,
    output logic [WIDTH-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_timeout,
    output logic             busy
);

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        LOAD    = 3'd1,
        PRIME   = 3'd2,
        ITER    = 3'd3,
        RESULT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAX_ITER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ld_nxt_s;
    logic             sel_nxt_s;
    logic             res_valid_nxt_s;
    logic             res_timeout_nxt_s;
    logic [WIDTH-1:0] res_data_nxt_s;
    logic             accept_s;
    logic             res_xfer_s;

    assign in_ready   = rst && (state_r == COLLECT);
    assign busy       = (state_r != COLLECT);
    assign accept_s   = in_valid && in_ready;
    assign res_xfer_s = res_valid && res_ready;

    // State, counters and strobe/result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= COLLECT;
            idx_r       <= 3'd0;
            cnt_r       <= {CNT_W{1'b0}};
            ld          <= 1'b0;
            sel         <= 1'b0;
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
            res_data    <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ld          <= ld_nxt_s;
            sel         <= sel_nxt_s;
            res_valid   <= res_valid_nxt_s;
            res_timeout <= res_timeout_nxt_s;
            res_data    <= res_data_nxt_s;
        end
    end

    // Frame slots; written only on acceptance so the datapath max mux sees stable x* until the next frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x1 <= {WIDTH{1'b0}};
            x2 <= {WIDTH{1'b0}};
            x3 <= {WIDTH{1'b0}};
            x4 <= {WIDTH{1'b0}};
            w1 <= {WIDTH{1'b0}};
            w2 <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            case (idx_r)
                3'd0:    x1 <= in_data;
                3'd1:    x2 <= in_data;
                3'd2:    x3 <= in_data;
                3'd3:    x4 <= in_data;
                3'd4:    w1 <= in_data;
                3'd5:    w2 <= in_data;
                default: ;
            endcase
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            COLLECT: begin
                if (accept_s && (idx_r == 3'd5)) state_nxt_s = LOAD;
                else                             state_nxt_s = COLLECT;
            end
            LOAD:    state_nxt_s = PRIME;
            PRIME:   state_nxt_s = ITER;
            ITER: begin
                if (dp_done || (cnt_r == LAST_ITER)) state_nxt_s = RESULT;
                else                                 state_nxt_s = ITER;
            end
            RESULT: begin
                if (res_xfer_s) state_nxt_s = COLLECT;
                else            state_nxt_s = RESULT;
            end
            default: state_nxt_s = COLLECT;
        endcase
    end

    // Next values of registered outputs and counters; dp_done is tested before the timeout so it wins a tie.
    always_comb begin
        ld_nxt_s          = (state_nxt_s == LOAD);
        sel_nxt_s         = (state_nxt_s == ITER) || (state_nxt_s == RESULT);
        idx_nxt_s         = idx_r;
        cnt_nxt_s         = cnt_r;
        res_valid_nxt_s   = res_valid;
        res_timeout_nxt_s = res_timeout;
        res_data_nxt_s    = res_data;
        case (state_r)
            COLLECT: begin
                if (accept_s) idx_nxt_s = (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
                else          idx_nxt_s = idx_r;
            end
            ITER: begin
                cnt_nxt_s = cnt_r + CNT_ONE;
                if (dp_done) begin
                    res_data_nxt_s    = dp_max;
                    res_timeout_nxt_s = 1'b0;
                    res_valid_nxt_s   = 1'b1;
                end else if (cnt_r == LAST_ITER) begin
                    res_data_nxt_s    = {WIDTH{1'b0}};
                    res_timeout_nxt_s = 1'b1;
                    res_valid_nxt_s   = 1'b1;
                end else begin
                    res_valid_nxt_s   = 1'b0;
                end
            end
            RESULT: begin
                if (res_xfer_s) begin
                    res_valid_nxt_s = 1'b0;
                    cnt_nxt_s       = {CNT_W{1'b0}};
                end else begin
                    res_valid_nxt_s = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_maxnet_frame_loader.sv
// Self-checking bench for maxnet_frame_loader: a real-valued Maxnet datapath model plus a
// programmable done/max stub, with expectations taken from the frame and latency rules.
`timescale 1ns/1ps
module tb_maxnet_frame_loader;
    localparam int MAX_ITER = 16;
    localparam int CNT_W    = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x1, x2, x3, x4, w1, w2;
    logic        ld, sel;
    logic        dp_done;
    logic [31:0] dp_max;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic        res_timeout;
    logic        busy;

    int checks = 0;
    int errors = 0;

    maxnet_frame_loader #(.WIDTH(32), .MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .w1(w1), .w2(w2), .ld(ld), .sel(sel),
        .dp_done(dp_done), .dp_max(dp_max), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycle-stamped event logs.
    int cyc = 0, acc_cnt = 0, acc_last = 0, ld_cnt = 0, ld_last = 0, iter_cnt = 0;
    int res_cnt = 0, rise_cyc = 0;
    logic rv_prev = 1'b0;
    int          acc_log_cyc [0:63];
    int          res_log_cyc [0:63];
    logic [31:0] res_log_data[0:63];
    logic        res_log_to  [0:63];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_last <= cyc;
            acc_log_cyc[acc_cnt % 64] <= cyc;
        end
        if (ld) begin
            ld_cnt <= ld_cnt + 1;
            ld_last <= cyc;
        end
        if (sel && !res_valid) iter_cnt <= iter_cnt + 1;
        rv_prev <= res_valid;
        if (res_valid && !rv_prev) rise_cyc <= cyc;
        if (res_valid && res_ready) begin
            res_log_cyc[res_cnt % 64]  <= cyc;
            res_log_data[res_cnt % 64] <= res_data;
            res_log_to[res_cnt % 64]   <= res_timeout;
            res_cnt <= res_cnt + 1;
        end
    end

    // Stub datapath: done in the stub_delay-th iterate cycle (0-based).
    logic        stub_en = 1'b0;
    int          stub_delay = 0;
    logic [31:0] stub_max = 32'h0;
    int          iter_k = 0;
    always @(posedge clk) iter_k <= (sel && !res_valid) ? iter_k + 1 : 0;

    // Real-valued Maxnet datapath: memory on ld, PUs take memory (sel=0) or lateral-inhibition feedback.
    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'h0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        if (e >= 0) for (int k = 0; k < e; k++) m = m * 2.0;
        else        for (int k = 0; k < -e; k++) m = m / 2.0;
        return b[31] ? -m : m;
    endfunction

    function automatic real relu(input real v);
        return (v > 0.0) ? v : 0.0;
    endfunction

    logic [31:0] xv [0:3];
    assign xv[0] = x1;
    assign xv[1] = x2;
    assign xv[2] = x3;
    assign xv[3] = x4;

    real mem [0:3];
    real pu  [0:3];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst) begin
                mem[i] <= 0.0;
                pu[i]  <= 0.0;
            end else begin
                if (ld) mem[i] <= f2r(xv[i]);
                pu[i] <= sel ? relu(f2r(w2) * pu[i] + f2r(w1) * (pu[0] + pu[1] + pu[2] + pu[3] - pu[i]))
                             : mem[i];
            end
        end
    end

    int npos, win;
    always_comb begin
        npos = 0;
        win  = 0;
        for (int i = 0; i < 4; i++) begin
            if (pu[i] > 0.0) begin
                npos = npos + 1;
                win  = i;
            end
        end
    end

    assign dp_done = stub_en ? (sel && !res_valid && (iter_k == stub_delay)) : (npos == 1);
    assign dp_max  = stub_en ? stub_max : xv[win];

    logic [31:0] frame_a [6] = '{32'h3E4CCCCD, 32'h3ECCCCCD, 32'h3F19999A, 32'h3F4CCCCD, 32'hBDCCCCCD, 32'h3F800000};
    logic [31:0] frame_b [6] = '{32'h3E99999A, 32'h3F333333, 32'h3E4CCCCD, 32'h3DCCCCCD, 32'hBDCCCCCD, 32'h3F800000};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] f [6], input int max_gap);
        int guard;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(max_gap, 0)) step();
            in_valid = 1'b1;
            in_data  = f[i];
            guard = 0;
            while (!in_ready && guard < 200) begin
                step();
                guard++;
            end
            if (guard >= 200) begin
                checks++;
                errors++;
                $display("FAIL send_word_timeout word %0d in_ready stayed 0", i);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int start, input int limit, output bit ok);
        int g = 0;
        while (res_cnt <= start && g < limit) begin
            step();
            g++;
        end
        ok = (res_cnt > start);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) step();
        checks++;
        if ({x1, x2, x3, x4, w1, w2, res_data} !== 224'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {x1, x2, x3, x4, w1, w2, res_data});
        end
        checks++;
        if ({ld, sel, res_valid, res_timeout, in_ready, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000", {ld, sel, res_valid, res_timeout, in_ready, busy});
        end
        rst = 1'b1;
        step();
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release got in_ready,busy=%b want 10", {in_ready, busy});
        end
    endtask

    task automatic test_real_frame(input int max_gap, input string tag);
        int a0, l0, r0;
        bit ok;
        stub_en = 1'b0;
        res_ready = 1'b1;
        a0 = acc_cnt; l0 = ld_cnt; r0 = res_cnt;
        send_frame(frame_a, max_gap);
        checks++;
        if (ld !== 1'b1) begin
            errors++;
            $display("FAIL %s_ld_n1 got %b want 1", tag, ld);
        end
        wait_res(r0, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_result_timeout got none want 1 result", tag);
        end else begin
            checks++;
            if ({res_log_data[r0 % 64], res_log_to[r0 % 64]} !== {32'h3F4CCCCD, 1'b0}) begin
                errors++;
                $display("FAIL %s_result got %h/%b want 3f4ccccd/0", tag, res_log_data[r0 % 64], res_log_to[r0 % 64]);
            end
        end
        checks++;
        if ({x1, x2, x3, x4, w1, w2} !== {frame_a[0], frame_a[1], frame_a[2], frame_a[3], frame_a[4], frame_a[5]}) begin
            errors++;
            $display("FAIL %s_frame_hold got %h %h %h %h %h %h", tag, x1, x2, x3, x4, w1, w2);
        end
        checks++;
        if (acc_cnt - a0 != 6 || ld_cnt - l0 != 1 || ld_last != acc_last + 1) begin
            errors++;
            $display("FAIL %s_words_ld got words=%0d lds=%0d ld_lat=%0d want 6 1 1", tag,
                     acc_cnt - a0, ld_cnt - l0, ld_last - acc_last);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] f [6];
        int r0, i0;
        bit ok;
        for (int i = 0; i < 6; i++) f[i] = $urandom;
        stub_en = 1'b1; stub_delay = 1000; stub_max = $urandom;
        res_ready = 1'b1;
        r0 = res_cnt; i0 = iter_cnt;
        send_frame(f, 1);
        wait_res(r0, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_none got no result want timeout result");
        end else begin
            checks++;
            if ({res_log_data[r0 % 64], res_log_to[r0 % 64]} !== {32'h0, 1'b1}) begin
                errors++;
                $display("FAIL timeout_result got %h/%b want 0/1", res_log_data[r0 % 64], res_log_to[r0 % 64]);
            end
            checks++;
            if (res_log_cyc[r0 % 64] - acc_last != 3 + MAX_ITER) begin
                errors++;
                $display("FAIL timeout_latency got %0d want %0d", res_log_cyc[r0 % 64] - acc_last, 3 + MAX_ITER);
            end
        end
        checks++;
        if (iter_cnt - i0 != MAX_ITER) begin
            errors++;
            $display("FAIL timeout_iter_cycles got %0d want %0d", iter_cnt - i0, MAX_ITER);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] f [6];
        int a0, r0, g;
        for (int i = 0; i < 6; i++) f[i] = $urandom;
        stub_en = 1'b1; stub_delay = 2; stub_max = $urandom;
        res_ready = 1'b0;
        r0 = res_cnt;
        send_frame(f, 0);
        g = 0;
        while (!res_valid && g < 100) begin
            step();
            g++;
        end
        in_valid = 1'b1;
        in_data  = $urandom;
        a0 = acc_cnt;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({res_valid, res_data, res_timeout, x1, w2, in_ready} !== {1'b1, stub_max, 1'b0, f[0], f[5], 1'b0}) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got v=%b d=%h t=%b x1=%h w2=%h rdy=%b want 1 %h 0 %h %h 0",
                         c, res_valid, res_data, res_timeout, x1, w2, in_ready, stub_max, f[0], f[5]);
            end
            step();
        end
        checks++;
        if (acc_cnt != a0) begin
            errors++;
            $display("FAIL stall_words got %0d consumed want 0", acc_cnt - a0);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        step();
        checks++;
        if ({res_valid, busy} !== 2'b00 || res_cnt - r0 != 1) begin
            errors++;
            $display("FAIL stall_release got v,busy=%b results=%0d want 00 1", {res_valid, busy}, res_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_iter();
        logic [31:0] f [6];
        int r0;
        bit ok;
        for (int i = 0; i < 6; i++) f[i] = $urandom;
        stub_en = 1'b1; stub_delay = 1000;
        res_ready = 1'b1;
        r0 = res_cnt;
        send_frame(f, 0);
        repeat (3) step();
        checks++;
        if ({sel, busy, res_valid} !== 3'b110) begin
            errors++;
            $display("FAIL midrst_pre got sel,busy,v=%b want 110", {sel, busy, res_valid});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({x1, x2, x3, x4, w1, w2, res_data, ld, sel, res_valid, res_timeout, in_ready, busy} !== 230'h0) begin
            errors++;
            $display("FAIL midrst_zero got %h want 0",
                     {x1, x2, x3, x4, w1, w2, res_data, ld, sel, res_valid, res_timeout, in_ready, busy});
        end
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({in_ready, busy} !== 2'b10 || res_cnt != r0) begin
            errors++;
            $display("FAIL midrst_after got rdy,busy=%b results=%0d want 10 0", {in_ready, busy}, res_cnt - r0);
        end
        test_real_frame(0, "midrst_next");
    endtask

    task automatic test_back_to_back();
        int a0, r0;
        bit ok;
        stub_en = 1'b0;
        res_ready = 1'b1;
        a0 = acc_cnt; r0 = res_cnt;
        send_frame(frame_a, 0);
        send_frame(frame_b, 0);
        wait_res(r0 + 1, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_count got %0d results want 2", res_cnt - r0);
        end else begin
            checks++;
            if ({res_log_data[r0 % 64], res_log_data[(r0 + 1) % 64]} !== {32'h3F4CCCCD, 32'h3F333333}) begin
                errors++;
                $display("FAIL b2b_order got %h %h want 3f4ccccd 3f333333",
                         res_log_data[r0 % 64], res_log_data[(r0 + 1) % 64]);
            end
            checks++;
            if (acc_log_cyc[(a0 + 6) % 64] != res_log_cyc[r0 % 64] + 1) begin
                errors++;
                $display("FAIL b2b_first_word got %0d cycles after transfer want 1",
                         acc_log_cyc[(a0 + 6) % 64] - res_log_cyc[r0 % 64]);
            end
        end
        checks++;
        if (x1 !== frame_b[0] || x2 !== frame_b[1]) begin
            errors++;
            $display("FAIL b2b_hold got %h %h want %h %h", x1, x2, frame_b[0], frame_b[1]);
        end
    endtask

    task automatic test_random();
        logic [31:0] f [6];
        int a0, l0, r0, g, d, rd, exp_rise;
        bit ok;
        logic [31:0] exp_data;
        logic        exp_to;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 6; i++) f[i] = $urandom;
            case (n % 4)
                0:       d = MAX_ITER - 1;
                1:       d = MAX_ITER;
                2:       d = 0;
                default: d = $urandom_range(MAX_ITER + 3, 0);
            endcase
            stub_en = 1'b1; stub_delay = d; stub_max = $urandom;
            rd = $urandom_range(3, 0);
            res_ready = (rd == 0);
            a0 = acc_cnt; l0 = ld_cnt; r0 = res_cnt;
            send_frame(f, 2);
            g = 0;
            while (!res_valid && g < 200) begin
                step();
                g++;
            end
            repeat (rd) step();
            res_ready = 1'b1;
            wait_res(r0, 50, ok);
            if (d < MAX_ITER) begin
                exp_data = stub_max; exp_to = 1'b0; exp_rise = acc_last + 4 + d;
            end else begin
                exp_data = 32'h0; exp_to = 1'b1; exp_rise = acc_last + 3 + MAX_ITER;
            end
            checks++;
            if (!ok || {res_log_data[r0 % 64], res_log_to[r0 % 64]} !== {exp_data, exp_to}) begin
                errors++;
                $display("FAIL rand%0d_result d=%0d got %h/%b want %h/%b", n, d,
                         res_log_data[r0 % 64], res_log_to[r0 % 64], exp_data, exp_to);
            end
            checks++;
            if (rise_cyc != exp_rise) begin
                errors++;
                $display("FAIL rand%0d_latency d=%0d got %0d want %0d", n, d, rise_cyc - acc_last, exp_rise - acc_last);
            end
            checks++;
            if ({x1, x2, x3, x4, w1, w2} !== {f[0], f[1], f[2], f[3], f[4], f[5]} ||
                acc_cnt - a0 != 6 || ld_cnt - l0 != 1 || ld_last != acc_last + 1) begin
                errors++;
                $display("FAIL rand%0d_frame got x1=%h w2=%h words=%0d lds=%0d want %h %h 6 1",
                         n, x1, w2, acc_cnt - a0, ld_cnt - l0, f[0], f[5]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_real_frame(0, "t1");
        test_real_frame(3, "t2");
        test_timeout();
        test_backpressure();
        test_reset_mid_iter();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
